// File: rtl/rr_mux4_arbiter.sv
// Four-requester round-robin arbiter feeding a one-word registered output buffer.
// The pointer names the highest-priority requester and moves just past each winner.
module rr_mux4_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             dbg_state_o,
  output logic [1:0]       dbg_ptr_o
);

  // Output handshake: a word moves when out_valid && out_ready on a rising edge;
  // out_valid never drops without that transfer (or reset), and data holds while stalled.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             cap;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] win_data;

  // First requesting index scanning upward from ptr_q, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_data = i0;
    case (win)
      2'd0: win_data = i0;
      2'd1: win_data = i1;
      2'd2: win_data = i2;
      2'd3: win_data = i3;
      default: win_data = i0;
    endcase
  end

  assign cap = (|req) && ((state_q == EMPTY) || out_ready) && !rst;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    gnt     = 4'b0000;
    if (cap) begin
      gnt     = 4'b0001 << win;
      state_d = FULL;
      ptr_d   = win + 2'd1;
      sel_d   = win;
      data_d  = win_data;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_data    = data_q;
  assign sel         = sel_q;
  assign dbg_state_o = (state_q == FULL);
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: a priority-list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_mux4_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] i0, i1, i2, i3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         dbg_state;
  logic [1:0]   dbg_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux4_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .dbg_state_o(dbg_state), .dbg_ptr_o(dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  bit           m_live = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] data_of(input int i);
    case (i)
      0: return i0;
      1: return i1;
      2: return i2;
      default: return i3;
    endcase
  endfunction

  // Winner: walk the priority list starting at the pointer; -1 if nobody asks.
  function automatic int pick(input int p, input logic [3:0] r);
    int order[$];
    for (int k = 0; k < 4; k++) order.push_back((p + k) % 4);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic bit model_cap();
    return !rst && (req != 4'b0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0; m_live = 1;
      exp_q.delete();
    end else if (m_live) begin
      if (model_cap()) begin
        int w;
        w = pick(m_ptr, req);
        m_data  = data_of(w);
        m_sel   = w;
        m_valid = 1;
        m_ptr   = (w + 1) % 4;
        exp_q.push_back(m_data);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Consumer-side scoreboard: every accepted word must be the oldest captured one.
  always @(posedge clk) begin
    if (!rst && m_live && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", out_data, 32'hFFFF_FFFF);
      else check("sb_word", out_data, exp_q.pop_front());
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      logic [3:0] eg;
      eg = 4'b0;
      if (model_cap()) eg = 4'(1 << pick(m_ptr, req));
      check("m_gnt", gnt, eg);
      check("m_valid", out_valid, m_valid);
      check("m_data", out_data, m_data);
      check("m_sel", sel, m_sel);
      check("m_ptr", dbg_ptr, m_ptr);
      check("m_state", dbg_state, m_valid);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [3:0] rot_gnt[5];
    int         rot_sel[5];
    rst = 1; req = 4'b1111; out_ready = 0;
    i0 = 8'h10; i1 = 8'h21; i2 = 8'h32; i3 = 8'h43;

    // Reset held two cycles with everyone requesting.
    settle();
    check("rst_gnt", gnt, 4'b0000);
    cycle(); cycle();
    check("rst_gnt2", gnt, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_sel", sel, 2'd0);

    // Single requester 2 from ptr=0.
    rst = 0; req = 4'b0100; i2 = 8'hA5; out_ready = 1;
    settle();
    check("single_gnt", gnt, 4'b0100);
    cycle();
    req = 4'b0000;
    settle();
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 8'hA5);
    check("single_sel", sel, 2'd2);
    check("single_ptr", dbg_ptr, 2'd3);
    // Drain with nobody requesting.
    cycle();
    check("drain_valid", out_valid, 1'b0);
    check("drain_data_kept", out_data, 8'hA5);

    // Rotation from a fresh reset.
    rst = 1; cycle(); rst = 0;
    i0 = 8'h10; i1 = 8'h21; i2 = 8'h32; i3 = 8'h43;
    rot_gnt[0] = 4'b0001; rot_gnt[1] = 4'b0010; rot_gnt[2] = 4'b0100;
    rot_gnt[3] = 4'b1000; rot_gnt[4] = 4'b0001;
    rot_sel[0] = 0; rot_sel[1] = 1; rot_sel[2] = 2; rot_sel[3] = 3; rot_sel[4] = 0;
    req = 4'b1111; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rot_gnt", gnt, rot_gnt[k]);
      cycle();
      check("rot_sel", sel, rot_sel[k]);
    end

    // Backpressure: load 8'h3C, then stall five cycles.
    req = 4'b0000; cycle();
    req = 4'b0001; i0 = 8'h3C; cycle();
    check("bp_load", out_data, 8'h3C);
    out_ready = 0; req = 4'b0011; i1 = 8'h77;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_gnt", gnt, 4'b0000);
      check("bp_data", out_data, 8'h3C);
      cycle();
    end
    out_ready = 1;
    settle();
    check("bp_release_gnt", gnt, 4'b0010);
    cycle();
    check("bp_release_data", out_data, 8'h77);

    // Wrap and skip: reach ptr=3, then 1 wins, then 0 wins.
    req = 4'b0100; cycle();
    check("wrap_ptr3", dbg_ptr, 2'd3);
    req = 4'b0010;
    settle();
    check("wrap_gnt1", gnt, 4'b0010);
    cycle();
    check("wrap_ptr2", dbg_ptr, 2'd2);
    req = 4'b0001;
    settle();
    check("wrap_gnt0", gnt, 4'b0001);
    cycle();
    check("wrap_ptr1", dbg_ptr, 2'd1);

    // Reset while full and stalled.
    out_ready = 0; req = 4'b1111; cycle();
    rst = 1;
    settle();
    check("midrst_gnt", gnt, 4'b0000);
    cycle();
    check("midrst_valid", out_valid, 1'b0);
    rst = 0;

    // Mixed traffic with withdrawal and stalls; the model checks every cycle.
    for (int k = 0; k < 300; k++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 3) != 0);
      i0 = 8'($urandom_range(0, 255)); i1 = 8'($urandom_range(0, 255));
      i2 = 8'($urandom_range(0, 255)); i3 = 8'($urandom_range(0, 255));
      cycle();
    end

    // No starvation: requester 3 held, others contend, granted within 4 captures.
    begin
      int caps;
      bit got;
      caps = 0; got = 0; out_ready = 1;
      for (int k = 0; k < 8 && !got; k++) begin
        req = 4'b1000 | 4'($urandom_range(0, 7));
        settle();
        if (gnt != 4'b0) caps++;
        if (gnt[3]) got = 1;
        cycle();
      end
      check("starve_granted", got, 1'b1);
      check("starve_within4", caps <= 4, 1'b1);
    end

    req = 4'b0; cycle(); cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
